mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opcode  input  6  instr[31:26], taken from the datapath instruction register (IR).
REQ-004 func  input  6  instr[5:0], taken from the IR.
REQ-005 zero  input  1  ALU equality flag (rs == rt).
REQ-006 pc_wr  output  1  PC <= NPC at the next edge.
REQ-007 npc_sel  output  2  NPC source: 00 PC+4, 01 branch target, 10 j/jal target, 11 GPR[rs].
REQ-008 ir_wr  output  1  IR loads the IM word at the current PC.
REQ-009 reg_wr  output  1  GPR write enable.
REQ-010 reg_dst  output  2  GPR write address: 00 rt, 01 rd, 10 $31.
REQ-011 wd_sel  output  2  GPR write data: 00 ALU result, 01 DM read data, 10 link (PC).
REQ-012 alu_src  output  1  ALU B operand: 0 GPR[rt], 1 extended immediate.
REQ-013 ext_op  output  2  Immediate extension: 00 zero-extend, 01 sign-extend, 10 imm<<16.
REQ-014 alu_op  output  3  ALU operation: 000 add, 001 sub, 010 or.
REQ-015 mem_wr  output  1  DM write enable.
REQ-016 instr_done  output  1  One-cycle pulse in the final cycle of each instruction.
REQ-017 illegal  output  1  One-cycle pulse in DECODE when the opcode/func pair is unsupported.
REQ-018 state  output  4  Current FSM state, for debug.

Function
REQ-019 Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop (all-zero word).
REQ-020 FSM states: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP.
REQ-021 FETCH outputs: ir_wr=1, pc_wr=1, npc_sel=00; next state DECODE.
REQ-022 DECODE transitions:
- addu/subu/ori/lui/lw/sw -> EXEC
- beq -> BRANCH
- j/jal/jr -> JUMP
- nop or illegal -> FETCH, with instr_done=1
REQ-023 EXEC: alu_op is add for addu/lw/sw, sub for subu, or for ori/lui; alu_src=1 for ori/lui/lw/sw; ext_op is 00 for ori, 10 for lui, 01 for lw/sw.
REQ-024 EXEC transitions: lw -> MEM_RD, sw -> MEM_WR, all others -> WB_ALU.
REQ-025 WB_ALU: reg_wr=1, wd_sel=00, reg_dst=01 for R-type and 00 for I-type, instr_done=1; next state FETCH.
REQ-026 MEM_RD -> WB_MEM with no write enables asserted.
REQ-027 WB_MEM: reg_wr=1, wd_sel=01, reg_dst=00, instr_done=1; next state FETCH.
REQ-028 MEM_WR: mem_wr=1, instr_done=1; next state FETCH.
REQ-029 BRANCH: alu_op=001, alu_src=0, ext_op=01, npc_sel=01, pc_wr=zero, instr_done=1; next state FETCH.
REQ-030 JUMP: pc_wr=1 and instr_done=1; next state FETCH.
- npc_sel=10 for j/jal, 11 for jr
- jal additionally asserts reg_wr=1, reg_dst=10, wd_sel=10; link is the PC already advanced in FETCH.
REQ-031 Every output not listed for a state SHALL be 0 in that state.
REQ-032 All outputs are combinational functions of state, opcode, func and zero, with no added latency.
REQ-033 Cycle counts: nop/illegal 2; beq/j/jal/jr 3; addu/subu/ori/lui/sw 4; lw 5.
REQ-034 Exactly one instr_done pulse per instruction; pc_wr is asserted at most twice per instruction (FETCH and the redirect).
REQ-035 mem_wr and reg_wr are never asserted in the same cycle.
REQ-036 Unreachable state encodings return to FETCH on the next edge, with all outputs 0.

Reset
REQ-037 While reset=1, every output except state SHALL be 0, and state SHALL read FETCH.
REQ-038 The first cycle after reset deasserts is FETCH.
REQ-039 Reset asserted mid-instruction aborts that instruction: no further write enable is asserted and no instr_done pulse is produced.

Structure
REQ-040 Shared package mc_pkg SHALL hold:
- opcode and func constants
- state encodings
- npc_sel, reg_dst, wd_sel, ext_op and alu_op encodings
REQ-041 One combinational sub-module, mc_decode, SHALL map opcode/func to an instruction-class one-hot plus an illegal flag; mc_ctrl SHALL hold the state register and the output logic.

Verification
REQ-042 Reset scenario: reset=1 for 3 cycles, then release -> all enables 0 during reset; ir_wr=1 and pc_wr=1 in the first cycle after release.
REQ-043 lw scenario: opcode=0x23 -> state sequence FETCH, DECODE, EXEC, MEM_RD, WB_MEM; reg_wr=1 with wd_sel=01 only in WB_MEM; instr_done=1 only in cycle 5.
REQ-044 beq scenario: opcode=0x04 with zero=1, then with zero=0 -> in BRANCH, pc_wr=1 with npc_sel=01 for zero=1, and pc_wr=0 for zero=0; 3 cycles each.
REQ-045 jal/jr scenario: opcode=0x03, then opcode=0x00 with func=0x08 -> in JUMP, jal gives npc_sel=10, reg_dst=10, reg_wr=1; jr gives npc_sel=11, reg_wr=0.
REQ-046 Illegal-opcode scenario: opcode=0x3F -> illegal=1 and instr_done=1 in DECODE, then FETCH; reg_wr=0 and mem_wr=0 throughout.
REQ-047 Reset-mid-op scenario: reset asserted during MEM_WR of sw (opcode=0x2B) -> mem_wr=0 in that cycle; state=FETCH after the edge.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: opcodes, function
// codes, FSM state encodings and datapath select encodings.
package mc_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned FN_W  = 6;
    localparam int unsigned ST_W  = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FN_W-1:0] FN_NOP   = 6'h00;
    localparam logic [FN_W-1:0] FN_JR    = 6'h08;
    localparam logic [FN_W-1:0] FN_ADDU  = 6'h21;
    localparam logic [FN_W-1:0] FN_SUBU  = 6'h23;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM_RD = 4'd3,
        ST_MEM_WR = 4'd4,
        ST_WB_ALU = 4'd5,
        ST_WB_MEM = 4'd6,
        ST_BRANCH = 4'd7,
        ST_JUMP   = 4'd8
    } state_t;

    localparam logic [SEL_W-1:0] NPC_PC4  = 2'b00;
    localparam logic [SEL_W-1:0] NPC_BR   = 2'b01;
    localparam logic [SEL_W-1:0] NPC_JMP  = 2'b10;
    localparam logic [SEL_W-1:0] NPC_RS   = 2'b11;

    localparam logic [SEL_W-1:0] DST_RT   = 2'b00;
    localparam logic [SEL_W-1:0] DST_RD   = 2'b01;
    localparam logic [SEL_W-1:0] DST_RA   = 2'b10;

    localparam logic [SEL_W-1:0] WD_ALU   = 2'b00;
    localparam logic [SEL_W-1:0] WD_MEM   = 2'b01;
    localparam logic [SEL_W-1:0] WD_LINK  = 2'b10;

    localparam logic [SEL_W-1:0] EXT_ZERO = 2'b00;
    localparam logic [SEL_W-1:0] EXT_SIGN = 2'b01;
    localparam logic [SEL_W-1:0] EXT_HI   = 2'b10;

    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'b010;

    // One-hot instruction class produced by the decoder
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic nop;
    } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/func decoder: one-hot instruction class plus an
// illegal flag when no supported instruction matches.
module mc_decode
    import mc_pkg::*;
(
    input  logic [OP_W-1:0] i_opcode,
    input  logic [FN_W-1:0] i_func,
    output instr_cls_t      o_cls_c,
    output logic            o_illegal_c
);

    always_comb begin
        o_cls_c = '0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_func)
                    FN_ADDU: o_cls_c.addu = 1'b1;
                    FN_SUBU: o_cls_c.subu = 1'b1;
                    FN_JR:   o_cls_c.jr   = 1'b1;
                    FN_NOP:  o_cls_c.nop  = 1'b1;
                    default: o_cls_c = '0;
                endcase
            end
            OP_ORI:  o_cls_c.ori = 1'b1;
            OP_LUI:  o_cls_c.lui = 1'b1;
            OP_LW:   o_cls_c.lw  = 1'b1;
            OP_SW:   o_cls_c.sw  = 1'b1;
            OP_BEQ:  o_cls_c.beq = 1'b1;
            OP_J:    o_cls_c.j   = 1'b1;
            OP_JAL:  o_cls_c.jal = 1'b1;
            default: o_cls_c = '0;
        endcase
    end

    assign o_illegal_c = (o_cls_c == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: state register plus combinational control outputs
// derived from the current state and the instruction held in the IR.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  opcode,
    input  logic [FN_W-1:0]  func,
    input  logic             zero,
    output logic             pc_wr,
    output logic [SEL_W-1:0] npc_sel,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic [SEL_W-1:0] reg_dst,
    output logic [SEL_W-1:0] wd_sel,
    output logic             alu_src,
    output logic [SEL_W-1:0] ext_op,
    output logic [ALU_W-1:0] alu_op,
    output logic             mem_wr,
    output logic             instr_done,
    output logic             illegal,
    output logic [ST_W-1:0]  state
);

    state_t     r_state;
    state_t     w_next_state;
    instr_cls_t w_cls;
    logic       w_illegal;

    mc_decode u_decode (
        .i_opcode    (opcode),
        .i_func      (func),
        .o_cls_c     (w_cls),
        .o_illegal_c (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Reset gates every output so an interrupted instruction issues no further writes
    always_comb begin
        w_next_state = ST_FETCH;
        pc_wr        = 1'b0;
        npc_sel      = NPC_PC4;
        ir_wr        = 1'b0;
        reg_wr       = 1'b0;
        reg_dst      = DST_RT;
        wd_sel       = WD_ALU;
        alu_src      = 1'b0;
        ext_op       = EXT_ZERO;
        alu_op       = ALU_ADD;
        mem_wr       = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    ir_wr        = 1'b1;
                    pc_wr        = 1'b1;
                    npc_sel      = NPC_PC4;
                    w_next_state = ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_cls.nop || w_illegal) begin
                        instr_done   = 1'b1;
                        illegal      = w_illegal;
                        w_next_state = ST_FETCH;
                    end else if (w_cls.beq) begin
                        w_next_state = ST_BRANCH;
                    end else if (w_cls.j || w_cls.jal || w_cls.jr) begin
                        w_next_state = ST_JUMP;
                    end else begin
                        w_next_state = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_cls.subu) begin
                        alu_op = ALU_SUB;
                    end else if (w_cls.ori || w_cls.lui) begin
                        alu_op = ALU_OR;
                    end
                    alu_src = w_cls.ori || w_cls.lui || w_cls.lw || w_cls.sw;
                    if (w_cls.lui) begin
                        ext_op = EXT_HI;
                    end else if (w_cls.lw || w_cls.sw) begin
                        ext_op = EXT_SIGN;
                    end
                    if (w_cls.lw) begin
                        w_next_state = ST_MEM_RD;
                    end else if (w_cls.sw) begin
                        w_next_state = ST_MEM_WR;
                    end else begin
                        w_next_state = ST_WB_ALU;
                    end
                end
                ST_MEM_RD: begin
                    w_next_state = ST_WB_MEM;
                end
                ST_MEM_WR: begin
                    mem_wr     = 1'b1;
                    instr_done = 1'b1;
                end
                ST_WB_ALU: begin
                    reg_wr     = 1'b1;
                    wd_sel     = WD_ALU;
                    reg_dst    = (w_cls.addu || w_cls.subu) ? DST_RD : DST_RT;
                    instr_done = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_wr     = 1'b1;
                    wd_sel     = WD_MEM;
                    reg_dst    = DST_RT;
                    instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    alu_op     = ALU_SUB;
                    alu_src    = 1'b0;
                    ext_op     = EXT_SIGN;
                    npc_sel    = NPC_BR;
                    pc_wr      = zero;
                    instr_done = 1'b1;
                end
                ST_JUMP: begin
                    pc_wr      = 1'b1;
                    instr_done = 1'b1;
                    npc_sel    = w_cls.jr ? NPC_RS : NPC_JMP;
                    if (w_cls.jal) begin
                        reg_wr  = 1'b1;
                        reg_dst = DST_RA;
                        wd_sel  = WD_LINK;
                    end
                end
                default: begin
                    w_next_state = ST_FETCH;
                end
            endcase
        end
    end

    assign state = reset ? ST_W'(ST_FETCH) : ST_W'(r_state);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected-output table run through
// a scoreboard queue, plus reset and reset-mid-instruction sequences.
module tb_mc_ctrl;

    typedef logic [21:0] vec_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        vec_t       exp;
        string      tag;
    } row_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       ir_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       mem_wr;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    int n_checks   = 0;
    int n_errors   = 0;
    int n_instr    = 0;
    int n_done     = 0;
    int n_conflict = 0;

    row_t  tbl[$];
    vec_t  exp_q[$];
    string tag_q[$];
    vec_t  v_f;
    vec_t  v_d;
    vec_t  v_zero;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .func       (func),
        .zero       (zero),
        .pc_wr      (pc_wr),
        .npc_sel    (npc_sel),
        .ir_wr      (ir_wr),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .alu_src    (alu_src),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .mem_wr     (mem_wr),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (instr_done) n_done++;
        if (mem_wr && reg_wr) n_conflict++;
    end

    // {state, pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wd_sel, alu_src, ext_op, alu_op, mem_wr, instr_done, illegal}
    function automatic vec_t mk(input logic [3:0] st, input logic pcw, input logic [1:0] npc,
                                input logic irw, input logic rw, input logic [1:0] dst,
                                input logic [1:0] wd, input logic src, input logic [1:0] ext,
                                input logic [2:0] alu, input logic mw, input logic done,
                                input logic ill);
        return {st, pcw, npc, irw, rw, dst, wd, src, ext, alu, mw, done, ill};
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input vec_t e, input string tag);
        tbl.push_back('{op, fn, z, e, tag});
    endtask

    task automatic add_fd(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input string tag);
        n_instr++;
        add(op, fn, z, v_f, tag);
        add(op, fn, z, v_d, tag);
    endtask

    task automatic check_out();
        vec_t  e;
        vec_t  a;
        string t;
        a = {state, pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wd_sel, alu_src,
             ext_op, alu_op, mem_wr, instr_done, illegal};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got %h required an expected entry", a);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got %h required %h", t, a, e);
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input vec_t e, input string tag);
        @(posedge clk);
        #1;
        reset  = rst;
        opcode = op;
        func   = fn;
        zero   = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'h23;
        func   = 6'h00;
        zero   = 1'b0;
        v_f    = mk(4'd0, 1, 2'b00, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
        v_d    = mk(4'd1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
        v_zero = '0;

        add_fd(6'h00, 6'h21, 0, "addu");
        add(6'h00, 6'h21, 0, mk(4'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0), "addu.ex");
        add(6'h00, 6'h21, 0, mk(4'd5, 0, 2'b00, 0, 1, 2'b01, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0), "addu.wb");
        add_fd(6'h00, 6'h23, 1, "subu");
        add(6'h00, 6'h23, 1, mk(4'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b001, 0, 0, 0), "subu.ex");
        add(6'h00, 6'h23, 1, mk(4'd5, 0, 2'b00, 0, 1, 2'b01, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0), "subu.wb");
        add_fd(6'h0D, 6'h15, 0, "ori");
        add(6'h0D, 6'h15, 0, mk(4'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b010, 0, 0, 0), "ori.ex");
        add(6'h0D, 6'h15, 0, mk(4'd5, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0), "ori.wb");
        add_fd(6'h0F, 6'h00, 0, "lui");
        add(6'h0F, 6'h00, 0, mk(4'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0), "lui.ex");
        add(6'h0F, 6'h00, 0, mk(4'd5, 0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0), "lui.wb");
        add_fd(6'h23, 6'h04, 0, "lw");
        add(6'h23, 6'h04, 0, mk(4'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b01, 3'b000, 0, 0, 0), "lw.ex");
        add(6'h23, 6'h04, 0, mk(4'd3, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0), "lw.memrd");
        add(6'h23, 6'h04, 0, mk(4'd6, 0, 2'b00, 0, 1, 2'b00, 2'b01, 0, 2'b00, 3'b000, 0, 1, 0), "lw.wb");
        add_fd(6'h2B, 6'h08, 0, "sw");
        add(6'h2B, 6'h08, 0, mk(4'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b01, 3'b000, 0, 0, 0), "sw.ex");
        add(6'h2B, 6'h08, 0, mk(4'd4, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1, 1, 0), "sw.memwr");
        add_fd(6'h04, 6'h10, 1, "beq1");
        add(6'h04, 6'h10, 1, mk(4'd7, 1, 2'b01, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b001, 0, 1, 0), "beq1.br");
        add_fd(6'h04, 6'h10, 0, "beq0");
        add(6'h04, 6'h10, 0, mk(4'd7, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b001, 0, 1, 0), "beq0.br");
        add_fd(6'h02, 6'h21, 1, "j");
        add(6'h02, 6'h21, 1, mk(4'd8, 1, 2'b10, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0), "j.jmp");
        add_fd(6'h03, 6'h00, 0, "jal");
        add(6'h03, 6'h00, 0, mk(4'd8, 1, 2'b10, 0, 1, 2'b10, 2'b10, 0, 2'b00, 3'b000, 0, 1, 0), "jal.jmp");
        add_fd(6'h00, 6'h08, 0, "jr");
        add(6'h00, 6'h08, 0, mk(4'd8, 1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0), "jr.jmp");
        n_instr++;
        add(6'h00, 6'h00, 0, v_f, "nop");
        add(6'h00, 6'h00, 0, mk(4'd1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 1, 0), "nop.dec");
        n_instr++;
        add(6'h3F, 6'h21, 0, v_f, "ill_op");
        add(6'h3F, 6'h21, 0, mk(4'd1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1), "ill_op.dec");
        n_instr++;
        add(6'h00, 6'h20, 0, v_f, "ill_fn");
        add(6'h00, 6'h20, 0, mk(4'd1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1), "ill_fn.dec");
        add(6'h00, 6'h00, 0, v_f, "post.fetch");

        // Reset held for three cycles: everything quiet, state reads FETCH
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 6'h23, 6'h00, 1'b0, v_zero, "reset");
        end

        foreach (tbl[i]) begin
            cyc(1'b0, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].exp, tbl[i].tag);
        end

        // sw interrupted by reset while in MEM_WR
        cyc(1'b1, 6'h2B, 6'h00, 1'b0, v_zero, "swrst.pre");
        cyc(1'b0, 6'h2B, 6'h00, 1'b0, v_f, "swrst.fetch");
        cyc(1'b0, 6'h2B, 6'h00, 1'b0, v_d, "swrst.dec");
        cyc(1'b0, 6'h2B, 6'h00, 1'b0,
            mk(4'd2, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b01, 3'b000, 0, 0, 0), "swrst.ex");
        @(posedge clk);
        #1;
        exp_q.push_back(mk(4'd4, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1, 1, 0));
        tag_q.push_back("swrst.memwr");
        check_out();
        reset = 1'b1;
        #1;
        exp_q.push_back(v_zero);
        tag_q.push_back("swrst.abort");
        check_out();
        cyc(1'b0, 6'h2B, 6'h00, 1'b0, v_f, "swrst.after");
        cyc(1'b0, 6'h2B, 6'h00, 1'b0, v_d, "swrst.after_dec");

        n_checks++;
        if (n_done != n_instr) begin
            n_errors++;
            $display("FAIL done_count: got %0d required %0d", n_done, n_instr);
        end
        n_checks++;
        if (n_conflict != 0) begin
            n_errors++;
            $display("FAIL memwr_regwr_overlap: got %0d cycles required 0", n_conflict);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
